regfile_wb: RTL and testbench



---
 rtl/cpu_pkg.sv | 16 +
 rtl/sat_counter.sv | 32 +++
 rtl/regfile_wb.sv | 77 +++++++
 tb/tb_regfile_wb.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit, four-register datapath.
// Instruction field positions are common to the dest and writeback stages.
package cpu_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 2;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam int RS_HI = 5;
    localparam int RS_LO = 4;
    localparam int RT_HI = 3;
    localparam int RT_LO = 2;
    localparam int RD_HI = 1;
    localparam int RD_LO = 0;

endpackage

// File: rtl/sat_counter.sv
// Unsigned up-counter that sticks at its all-ones value.
// Synchronous active-high clear.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic             Inc,
    output logic [CNT_W-1:0] Count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (Inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Count = count_q;

endmodule

// File: rtl/regfile_wb.sv
// Writeback register file: aligns RegWrite with the dest-stage index,
// commits Write_Data, bypasses reads, and exposes a debug read port.
module regfile_wb
    import cpu_pkg::*;
#(
    parameter int REG_DATA_W = cpu_pkg::DATA_W,
    parameter int REG_ADDR_W = cpu_pkg::ADDR_W,
    parameter int CNT_W      = 8
) (
    input  logic                  Clk,
    input  logic                  Clear,
    input  logic                  RegWrite,
    input  logic [REG_ADDR_W-1:0] Write_Register,
    input  logic [REG_DATA_W-1:0] Write_Data,
    input  logic [REG_ADDR_W-1:0] Read_Register1,
    input  logic [REG_ADDR_W-1:0] Read_Register2,
    output logic [REG_DATA_W-1:0] Read_Data1,
    output logic [REG_DATA_W-1:0] Read_Data2,
    input  logic [REG_ADDR_W-1:0] Dbg_Sel,
    output logic [REG_DATA_W-1:0] Dbg_Data,
    output logic [CNT_W-1:0]      Write_Count,
    output logic                  Hazard
);

    localparam int N_REGS = 2 ** REG_ADDR_W;

    logic                  we_q;
    logic                  we_d;
    logic [REG_DATA_W-1:0] regs_q [N_REGS];
    logic [REG_DATA_W-1:0] regs_d [N_REGS];
    logic [REG_DATA_W-1:0] dbg_q;
    logic [REG_DATA_W-1:0] dbg_d;
    logic                  hit1;
    logic                  hit2;

    // RegWrite leads Write_Register by one cycle; we_q lines them up.
    always_comb begin
        we_d   = RegWrite;
        dbg_d  = regs_q[Dbg_Sel];
        regs_d = regs_q;
        if (we_q) begin
            regs_d[Write_Register] = Write_Data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Clear) begin
            we_q   <= 1'b0;
            dbg_q  <= '0;
            regs_q <= '{default: '0};
        end else begin
            we_q   <= we_d;
            dbg_q  <= dbg_d;
            regs_q <= regs_d;
        end
    end

    always_comb begin
        hit1       = we_q && (Read_Register1 == Write_Register);
        hit2       = we_q && (Read_Register2 == Write_Register);
        Read_Data1 = hit1 ? Write_Data : regs_q[Read_Register1];
        Read_Data2 = hit2 ? Write_Data : regs_q[Read_Register2];
        Hazard     = hit1 || hit2;
    end

    assign Dbg_Data = dbg_q;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .Clk  (Clk),
        .Clear(Clear),
        .Inc  (we_q),
        .Count(Write_Count)
    );

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: bypass, commit, debug lag,
// clear priority and counter saturation.
module tb_regfile_wb;

    logic       clk;
    logic       clear;
    logic       reg_write;
    logic [1:0] wr_reg;
    logic [7:0] wr_data;
    logic [1:0] rr1;
    logic [1:0] rr2;
    logic [7:0] rd1;
    logic [7:0] rd2;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;
    logic [7:0] wcount;
    logic       hazard;

    int passed = 0;
    int total  = 0;

    regfile_wb dut (
        .Clk           (clk),
        .Clear         (clear),
        .RegWrite      (reg_write),
        .Write_Register(wr_reg),
        .Write_Data    (wr_data),
        .Read_Register1(rr1),
        .Read_Register2(rr2),
        .Read_Data1    (rd1),
        .Read_Data2    (rd2),
        .Dbg_Sel       (dbg_sel),
        .Dbg_Data      (dbg_data),
        .Write_Count   (wcount),
        .Hazard        (hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    endtask

    initial begin
        clear     = 1'b1;
        reg_write = 1'b0;
        wr_reg    = 2'd0;
        wr_data   = 8'h00;
        rr1       = 2'd0;
        rr2       = 2'd0;
        dbg_sel   = 2'd0;
        tick();
        tick();
        clear = 1'b0;
        #1;

        // Reset state on every index
        for (int r = 0; r < 4; r++) begin
            rr1 = 2'(r);
            rr2 = 2'(3 - r);
            #1;
            chk($sformatf("rst_rd1_%0d", r), rd1, 8'h00);
            chk($sformatf("rst_rd2_%0d", r), rd2, 8'h00);
        end
        chk("rst_hazard", {7'd0, hazard}, 8'h00);
        chk("rst_count", wcount, 8'h00);
        chk("rst_dbg", dbg_data, 8'h00);

        // Single write to reg2: bypass then committed
        reg_write = 1'b1;
        tick();
        reg_write = 1'b0;
        wr_reg    = 2'd2;
        wr_data   = 8'hA5;
        rr1       = 2'd2;
        rr2       = 2'd0;
        #1;
        chk("byp_rd1", rd1, 8'hA5);
        chk("byp_rd2_other", rd2, 8'h00);
        chk("byp_hazard", {7'd0, hazard}, 8'h01);
        tick();
        wr_data = 8'h5A;
        #1;
        chk("cmt_rd1", rd1, 8'hA5);
        chk("cmt_hazard", {7'd0, hazard}, 8'h00);
        chk("cmt_count", wcount, 8'h01);

        // No write enable: nothing commits, nothing bypasses
        wr_reg  = 2'd1;
        wr_data = 8'h3C;
        rr1     = 2'd1;
        #1;
        chk("nowe_rd1", rd1, 8'h00);
        chk("nowe_hazard", {7'd0, hazard}, 8'h00);
        tick();
        chk("nowe_rd1_after", rd1, 8'h00);
        chk("nowe_count", wcount, 8'h01);

        // Back-to-back writes to reg3
        dbg_sel   = 2'd3;
        reg_write = 1'b1;
        tick();
        wr_reg  = 2'd3;
        wr_data = 8'h11;
        rr1     = 2'd3;
        rr2     = 2'd3;
        #1;
        chk("b2b_rd1_a", rd1, 8'h11);
        chk("b2b_rd2_a", rd2, 8'h11);
        chk("b2b_hazard", {7'd0, hazard}, 8'h01);
        tick();
        reg_write = 1'b0;
        wr_data   = 8'h22;
        #1;
        chk("b2b_rd1_b", rd1, 8'h22);
        chk("b2b_rd2_b", rd2, 8'h22);
        chk("b2b_dbg_pre", dbg_data, 8'h00);
        tick();
        rr2 = 2'd2;
        #1;
        chk("b2b_rd1_final", rd1, 8'h22);
        chk("b2b_reg2_kept", rd2, 8'hA5);
        chk("b2b_dbg_lag", dbg_data, 8'h11);
        chk("b2b_count", wcount, 8'h03);
        tick();
        chk("b2b_dbg", dbg_data, 8'h22);

        // Clear on the commit edge drops the write
        reg_write = 1'b1;
        tick();
        reg_write = 1'b0;
        wr_reg    = 2'd0;
        wr_data   = 8'hFF;
        clear     = 1'b1;
        tick();
        clear = 1'b0;
        rr1   = 2'd0;
        rr2   = 2'd3;
        #1;
        chk("clr_rd1", rd1, 8'h00);
        chk("clr_reg3", rd2, 8'h00);
        chk("clr_count", wcount, 8'h00);
        chk("clr_hazard", {7'd0, hazard}, 8'h00);
        tick();
        chk("clr_rd1_after", rd1, 8'h00);
        chk("clr_dbg", dbg_data, 8'h00);

        // Clear in the RegWrite cycle also loses the write
        reg_write = 1'b1;
        clear     = 1'b1;
        tick();
        clear     = 1'b0;
        reg_write = 1'b0;
        wr_reg    = 2'd1;
        wr_data   = 8'h77;
        rr1       = 2'd1;
        #1;
        chk("clr2_hazard", {7'd0, hazard}, 8'h00);
        chk("clr2_rd1", rd1, 8'h00);
        tick();
        chk("clr2_rd1_after", rd1, 8'h00);
        chk("clr2_count", wcount, 8'h00);

        // 260 committed writes saturate the counter
        wr_reg    = 2'd0;
        reg_write = 1'b1;
        tick();
        for (int i = 0; i < 260; i++) begin
            wr_data = 8'(i);
            tick();
            if (i == 253) chk("sat_254", wcount, 8'd254);
            if (i == 254) chk("sat_255", wcount, 8'd255);
        end
        reg_write = 1'b0;
        tick();
        tick();
        rr1 = 2'd0;
        #1;
        chk("sat_hold", wcount, 8'd255);
        chk("sat_reg0", rd1, 8'h03);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
